// File: rtl/cache_pkg.sv
// Shared types and sizing for the cache data-array line mover.
// Fixes the line geometry (128-bit line, 8 x 16-bit beats) and the mover FSM states.
package cache_pkg;

  localparam int unsigned LINE_BITS = 128;
  localparam int unsigned WORD_BITS = 16;
  localparam int unsigned BEATS     = 8;
  localparam int unsigned BEAT_W    = 3;
  localparam int unsigned SEG_W     = 9;
  localparam int unsigned WAY_W     = 2;

  typedef enum logic [3:0] {
    IDLE,
    WB_RD,
    WB_CAP,
    WB_CMD,
    WB_DAT,
    RF_CMD,
    RF_DAT,
    RF_WR,
    DONE
  } mover_state_t;

  function automatic logic is_last_beat(input logic [BEAT_W-1:0] beat);
    return beat == BEAT_W'(BEATS - 1);
  endfunction

endpackage

// File: rtl/cache_line_mover_if.sv
// Controller, cache data-array and memory-port signals of the line mover.
// master = the mover itself, slave = its environment.
interface cache_line_mover_if #(
  parameter int unsigned LINE_ADDR_W = 26
);
  import cache_pkg::*;

  logic                   req_valid;
  logic                   req_ready;
  logic                   req_writeback;
  logic                   req_fill;
  logic [SEG_W-1:0]       req_segment;
  logic [WAY_W-1:0]       req_way;
  logic [LINE_ADDR_W-1:0] req_wb_addr;
  logic [LINE_ADDR_W-1:0] req_fill_addr;
  logic                   done;

  logic [SEG_W-1:0]       cache_segment;
  logic [WAY_W-1:0]       cache_way;
  logic                   cache_full_write;
  logic [LINE_BITS-1:0]   cache_raw_in;
  logic [LINE_BITS-1:0]   cache_raw_out;
  logic                   cache_dirty;

  logic                   mem_cmd_valid;
  logic                   mem_cmd_ready;
  logic                   mem_cmd_write;
  logic [LINE_ADDR_W-1:0] mem_cmd_addr;
  logic                   mem_wdata_valid;
  logic                   mem_wdata_ready;
  logic [WORD_BITS-1:0]   mem_wdata;
  logic                   mem_rdata_valid;
  logic [WORD_BITS-1:0]   mem_rdata;

  modport master (
    input  req_valid, req_writeback, req_fill, req_segment, req_way,
           req_wb_addr, req_fill_addr,
    output req_ready, done,
    output cache_segment, cache_way, cache_full_write, cache_raw_in,
    input  cache_raw_out, cache_dirty,
    output mem_cmd_valid, mem_cmd_write, mem_cmd_addr,
    input  mem_cmd_ready,
    output mem_wdata_valid, mem_wdata,
    input  mem_wdata_ready,
    input  mem_rdata_valid, mem_rdata
  );

  modport slave (
    output req_valid, req_writeback, req_fill, req_segment, req_way,
           req_wb_addr, req_fill_addr,
    input  req_ready, done,
    input  cache_segment, cache_way, cache_full_write, cache_raw_in,
    output cache_raw_out, cache_dirty,
    input  mem_cmd_valid, mem_cmd_write, mem_cmd_addr,
    output mem_cmd_ready,
    input  mem_wdata_valid, mem_wdata,
    output mem_wdata_ready,
    output mem_rdata_valid, mem_rdata
  );

endinterface

// File: rtl/cache_line_serdes.sv
// One-line buffer with a 3-bit beat counter: parallel load, beat-wise read-out, beat-wise fill.
// The counter wraps 7->0 on the last beat, so each burst starts from beat 0.
module cache_line_serdes
  import cache_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_load,
  input  logic [LINE_BITS-1:0] i_line,
  input  logic                 i_shift_out,
  input  logic                 i_shift_in,
  input  logic [WORD_BITS-1:0] i_word,
  output logic [LINE_BITS-1:0] o_line,
  output logic [WORD_BITS-1:0] o_word,
  output logic                 o_last
);

  logic [LINE_BITS-1:0] r_line;
  logic [BEAT_W-1:0]    r_beat;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_line <= '0;
      r_beat <= '0;
    end else if (i_load) begin
      r_line <= i_line;
      r_beat <= '0;
    end else if (i_shift_out) begin
      r_beat <= r_beat + BEAT_W'(1);
    end else if (i_shift_in) begin
      r_line[WORD_BITS*r_beat +: WORD_BITS] <= i_word;
      r_beat                                <= r_beat + BEAT_W'(1);
    end
  end

  always_comb begin
    o_line = r_line;
    o_word = r_line[WORD_BITS*r_beat +: WORD_BITS];
    o_last = is_last_beat(r_beat);
  end

endmodule

// File: rtl/cache_line_mover.sv
// Line mover: evicts a cache line to memory as 8 beats and/or refills it from 8 memory beats.
// Build option CACHE_LINE_MOVER_SKIP_CLEAN_EN skips the memory write for clean lines.
module cache_line_mover
  import cache_pkg::*;
#(
  parameter int unsigned LINE_ADDR_W = 26
) (
  input  logic                main_clk,
  input  logic                main_rst_n,
  cache_line_mover_if.master  bus
);

  mover_state_t           r_state;
  mover_state_t           w_next;
  logic                   r_writeback;
  logic                   r_fill;
  logic [SEG_W-1:0]       r_segment;
  logic [WAY_W-1:0]       r_way;
  logic [LINE_ADDR_W-1:0] r_wb_addr;
  logic [LINE_ADDR_W-1:0] r_fill_addr;

  logic                   w_load;
  logic                   w_shift_out;
  logic                   w_shift_in;
  logic [LINE_BITS-1:0]   w_line;
  logic [WORD_BITS-1:0]   w_word;
  logic                   w_last;

  cache_line_serdes u_serdes (
    .i_clk       (main_clk),
    .i_rst_n     (main_rst_n),
    .i_load      (w_load),
    .i_line      (bus.cache_raw_out),
    .i_shift_out (w_shift_out),
    .i_shift_in  (w_shift_in),
    .i_word      (bus.mem_rdata),
    .o_line      (w_line),
    .o_word      (w_word),
    .o_last      (w_last)
  );

`ifndef CACHE_LINE_MOVER_SKIP_CLEAN_EN
  logic w_unused_dirty;
  assign w_unused_dirty = bus.cache_dirty;
`endif

  always_ff @(posedge main_clk) begin
    if (!main_rst_n) begin
      r_state     <= IDLE;
      r_writeback <= 1'b0;
      r_fill      <= 1'b0;
      r_segment   <= '0;
      r_way       <= '0;
      r_wb_addr   <= '0;
      r_fill_addr <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && bus.req_valid) begin
        r_writeback <= bus.req_writeback;
        r_fill      <= bus.req_fill;
        r_segment   <= bus.req_segment;
        r_way       <= bus.req_way;
        r_wb_addr   <= bus.req_wb_addr;
        r_fill_addr <= bus.req_fill_addr;
      end
    end
  end

  always_comb begin
    w_next               = r_state;
    w_load               = 1'b0;
    w_shift_out          = 1'b0;
    w_shift_in           = 1'b0;
    bus.req_ready        = 1'b0;
    bus.done             = 1'b0;
    bus.cache_segment    = r_segment;
    bus.cache_way        = r_way;
    bus.cache_full_write = 1'b0;
    bus.cache_raw_in     = w_line;
    bus.mem_cmd_valid    = 1'b0;
    bus.mem_cmd_write    = 1'b0;
    bus.mem_cmd_addr     = r_fill_addr;
    bus.mem_wdata_valid  = 1'b0;
    bus.mem_wdata        = w_word;

    case (r_state)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          if (bus.req_writeback)  w_next = WB_RD;
          else if (bus.req_fill)  w_next = RF_CMD;
          else                    w_next = DONE;
        end
      end
      WB_RD: w_next = WB_CAP;
      WB_CAP: begin
        w_load = 1'b1;
`ifdef CACHE_LINE_MOVER_SKIP_CLEAN_EN
        if (!bus.cache_dirty) w_next = r_fill ? RF_CMD : DONE;
        else                  w_next = WB_CMD;
`else
        w_next = WB_CMD;
`endif
      end
      WB_CMD: begin
        bus.mem_cmd_valid = 1'b1;
        bus.mem_cmd_write = 1'b1;
        bus.mem_cmd_addr  = r_wb_addr;
        if (bus.mem_cmd_ready) w_next = WB_DAT;
      end
      WB_DAT: begin
        bus.mem_wdata_valid = 1'b1;
        if (bus.mem_wdata_ready) begin
          w_shift_out = 1'b1;
          if (w_last) w_next = r_fill ? RF_CMD : DONE;
        end
      end
      RF_CMD: begin
        bus.mem_cmd_valid = 1'b1;
        if (bus.mem_cmd_ready) w_next = RF_DAT;
      end
      RF_DAT: begin
        if (bus.mem_rdata_valid) begin
          w_shift_in = 1'b1;
          if (w_last) w_next = RF_WR;
        end
      end
      RF_WR: begin
        bus.cache_full_write = 1'b1;
        w_next               = DONE;
      end
      DONE: begin
        bus.done = 1'b1;
        w_next   = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

endmodule
